// File: rtl/aes_decrypt_ctrl.sv
// Sequencing controller for the iterative AES-128 decryption datapath.
// Walks load, key-expansion wait, inverse rounds and plaintext write-back; holds no cipher data.
module aes_decrypt_ctrl #(
  parameter int unsigned NUM_ROUNDS    = 10,
  parameter int unsigned KEYEXP_CYCLES = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       STATE_LD,
  output logic       STATE_WE,
  output logic [2:0] OP_SEL,
  output logic [3:0] ROUND_KEY_IDX,
  output logic [1:0] COL_SEL,
  output logic       PT_WE
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned COL_W = 2;
  localparam int unsigned KXP_W = 8;

  localparam logic [OP_W-1:0]  OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0]  OP_ARK  = 3'd1;
  localparam logic [OP_W-1:0]  OP_ISR  = 3'd2;
  localparam logic [OP_W-1:0]  OP_ISB  = 3'd3;
  localparam logic [OP_W-1:0]  OP_IMC  = 3'd4;

  localparam logic [IDX_W-1:0] INIT_KEY_IDX   = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] FIRST_LOOP_RND = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [KXP_W-1:0] KEYEXP_LAST    = KXP_W'(KEYEXP_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST       = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_KEYEXP,
    S_ARK_INIT,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_F_ISR,
    S_F_ISB,
    S_F_ARK,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [KXP_W-1:0] keyexp_cnt, keyexp_d;
  logic [IDX_W-1:0] round_cnt, round_d;
  logic [COL_W-1:0] col_cnt, col_d;

  logic             done_d, busy_d, ld_d, we_d, pt_d;
  logic [OP_W-1:0]  op_d;
  logic [IDX_W-1:0] idx_d;
  logic [COL_W-1:0] col_sel_d;

  // State, counters and outputs; outputs are registered from the next-state decode
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      keyexp_cnt    <= '0;
      round_cnt     <= '0;
      col_cnt       <= '0;
      AES_DONE      <= 1'b0;
      BUSY          <= 1'b0;
      STATE_LD      <= 1'b0;
      STATE_WE      <= 1'b0;
      OP_SEL        <= OP_HOLD;
      ROUND_KEY_IDX <= '0;
      COL_SEL       <= '0;
      PT_WE         <= 1'b0;
    end else begin
      state         <= state_d;
      keyexp_cnt    <= keyexp_d;
      round_cnt     <= round_d;
      col_cnt       <= col_d;
      AES_DONE      <= done_d;
      BUSY          <= busy_d;
      STATE_LD      <= ld_d;
      STATE_WE      <= we_d;
      OP_SEL        <= op_d;
      ROUND_KEY_IDX <= idx_d;
      COL_SEL       <= col_sel_d;
      PT_WE         <= pt_d;
    end
  end

  // Next state and counter updates
  always_comb begin
    state_d  = state;
    keyexp_d = keyexp_cnt;
    round_d  = round_cnt;
    col_d    = col_cnt;
    case (state)
      S_IDLE: begin
        if (AES_START) begin
          state_d  = S_LOAD;
          keyexp_d = '0;
          round_d  = '0;
          col_d    = '0;
        end
      end
      S_LOAD:   state_d = S_KEYEXP;
      S_KEYEXP: begin
        if (keyexp_cnt == KEYEXP_LAST) begin
          state_d = S_ARK_INIT;
        end else begin
          keyexp_d = keyexp_cnt + KXP_W'(1);
        end
      end
      S_ARK_INIT: begin
        state_d = S_ISR;
        round_d = FIRST_LOOP_RND;
      end
      S_ISR: state_d = S_ISB;
      S_ISB: state_d = S_ARK;
      S_ARK: state_d = S_IMC;
      S_IMC: begin
        if (col_cnt == COL_LAST) begin
          col_d   = '0;
          round_d = round_cnt - IDX_W'(1);
          state_d = (round_cnt == IDX_W'(1)) ? S_F_ISR : S_ISR;
        end else begin
          col_d = col_cnt + COL_W'(1);
        end
      end
      S_F_ISR: state_d = S_F_ISB;
      S_F_ISB: state_d = S_F_ARK;
      S_F_ARK: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      // Hold done while start stays high so a level start cannot retrigger
      S_DONE: begin
        if (!AES_START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state
  always_comb begin
    done_d    = 1'b0;
    busy_d    = 1'b1;
    ld_d      = 1'b0;
    we_d      = 1'b0;
    pt_d      = 1'b0;
    op_d      = OP_HOLD;
    idx_d     = '0;
    col_sel_d = '0;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_LOAD:   ld_d = 1'b1;
      S_KEYEXP: op_d = OP_HOLD;
      S_ARK_INIT: begin
        op_d  = OP_ARK;
        idx_d = INIT_KEY_IDX;
        we_d  = 1'b1;
      end
      S_ISR, S_F_ISR: begin
        op_d = OP_ISR;
        we_d = 1'b1;
      end
      S_ISB, S_F_ISB: begin
        op_d = OP_ISB;
        we_d = 1'b1;
      end
      S_ARK: begin
        op_d  = OP_ARK;
        idx_d = round_d;
        we_d  = 1'b1;
      end
      S_F_ARK: begin
        op_d = OP_ARK;
        we_d = 1'b1;
      end
      S_IMC: begin
        op_d      = OP_IMC;
        col_sel_d = col_d;
        we_d      = 1'b1;
      end
      S_WRITE: pt_d = 1'b1;
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl: default instance plus a NUM_ROUNDS=2 / KEYEXP_CYCLES=1 corner instance.
module tb_aes_decrypt_ctrl;

  logic       Clk;
  logic       Reset;
  logic       start_a, start_b;
  logic       done_a, busy_a, ld_a, we_a, pt_a;
  logic [2:0] op_a;
  logic [3:0] idx_a;
  logic [1:0] col_a;
  logic       done_b, busy_b, ld_b, we_b, pt_b;
  logic [2:0] op_b;
  logic [3:0] idx_b;
  logic [1:0] col_b;

  int checks = 0;
  int errors = 0;

  aes_decrypt_ctrl dut_a (
    .Clk(Clk), .Reset(Reset), .AES_START(start_a),
    .AES_DONE(done_a), .BUSY(busy_a), .STATE_LD(ld_a), .STATE_WE(we_a),
    .OP_SEL(op_a), .ROUND_KEY_IDX(idx_a), .COL_SEL(col_a), .PT_WE(pt_a)
  );

  aes_decrypt_ctrl #(.NUM_ROUNDS(2), .KEYEXP_CYCLES(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .AES_START(start_b),
    .AES_DONE(done_b), .BUSY(busy_b), .STATE_LD(ld_b), .STATE_WE(we_b),
    .OP_SEL(op_b), .ROUND_KEY_IDX(idx_b), .COL_SEL(col_b), .PT_WE(pt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // View of the selected instance for the shared trace recorder
  int         sel = 0;
  logic       v_done, v_busy, v_ld, v_we, v_pt;
  logic [2:0] v_op;
  logic [3:0] v_idx;
  logic [1:0] v_col;
  always_comb begin
    if (sel == 0) begin
      v_done = done_a; v_busy = busy_a; v_ld = ld_a; v_we = we_a; v_pt = pt_a;
      v_op = op_a; v_idx = idx_a; v_col = col_a;
    end else begin
      v_done = done_b; v_busy = busy_b; v_ld = ld_b; v_we = we_b; v_pt = pt_b;
      v_op = op_b; v_idx = idx_b; v_col = col_b;
    end
  end

  int strokes, ark_n, imc_n, pt_cnt, pt_k, done_cnt, done_first, ld_cnt, first_ark_k, overlap, multi;
  logic [3:0] ark_keys [0:15];
  logic [1:0] imc_cols [0:63];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Records ncyc observed cycles; the cycle currently visible is k=0
  task automatic trace(input int ncyc);
    strokes = 0; ark_n = 0; imc_n = 0; pt_cnt = 0; pt_k = -1; done_cnt = 0;
    done_first = -1; ld_cnt = 0; first_ark_k = -1; overlap = 0; multi = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (v_we) begin
        strokes++;
        if (v_op == 3'd1) begin
          if (first_ark_k < 0) first_ark_k = k;
          if (ark_n < 16) ark_keys[ark_n] = v_idx;
          ark_n++;
        end
        if (v_op == 3'd4) begin
          if (imc_n < 64) imc_cols[imc_n] = v_col;
          imc_n++;
        end
      end
      if (v_ld) ld_cnt++;
      if (v_ld && v_we) overlap++;
      if ((32'(v_ld) + 32'(v_we) + 32'(v_pt)) > 1) multi++;
      if (v_pt) begin pt_cnt++; pt_k = k; end
      if (v_done) begin
        done_cnt++;
        if (done_first < 0) done_first = k;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick(); tick();
    checks++;
    if ({done_a, busy_a, ld_a, we_a, op_a, idx_a, col_a, pt_a} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %h expected 0", {done_a, busy_a, ld_a, we_a, op_a, idx_a, col_a, pt_a});
    end
    checks++;
    if ({done_b, busy_b, ld_b, we_b, op_b, idx_b, col_b, pt_b} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs_b: got %h expected 0", {done_b, busy_b, ld_b, we_b, op_b, idx_b, col_b, pt_b});
    end
  endtask

  task automatic test_nominal();
    sel = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++;
    if (ld_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL nominal_load: ld=%b busy=%b expected 1 1", ld_a, busy_a);
    end
    trace(85);
    checks++;
    if (strokes != 67) begin errors++; $display("FAIL nominal_strokes: got %0d expected 67", strokes); end
    checks++;
    if (first_ark_k != 11) begin errors++; $display("FAIL nominal_ark_init_cycle: got %0d expected 11", first_ark_k); end
    checks++;
    if (ark_n != 11) begin errors++; $display("FAIL nominal_ark_count: got %0d expected 11", ark_n); end
    for (int i = 0; i < 11 && i < ark_n; i++) begin
      checks++;
      if (ark_keys[i] !== 4'(10 - i)) begin
        errors++; $display("FAIL nominal_ark_key[%0d]: got %0d expected %0d", i, ark_keys[i], 10 - i);
      end
    end
    checks++;
    if (imc_n != 36) begin errors++; $display("FAIL nominal_imc_count: got %0d expected 36", imc_n); end
    for (int i = 0; i < 36 && i < imc_n; i++) begin
      checks++;
      if (imc_cols[i] !== 2'(i % 4)) begin
        errors++; $display("FAIL nominal_col[%0d]: got %0d expected %0d", i, imc_cols[i], i % 4);
      end
    end
    checks++;
    if (pt_cnt != 1 || pt_k != 78) begin errors++; $display("FAIL nominal_pt_we: count=%0d at=%0d expected 1 at 78", pt_cnt, pt_k); end
    checks++;
    if (done_first != 79 || done_cnt != 1) begin errors++; $display("FAIL nominal_done: first=%0d count=%0d expected 79 1", done_first, done_cnt); end
    checks++;
    if (ld_cnt != 1) begin errors++; $display("FAIL nominal_ld_count: got %0d expected 1", ld_cnt); end
    checks++;
    if (overlap != 0 || multi != 0) begin errors++; $display("FAIL nominal_strobe_overlap: overlap=%0d multi=%0d expected 0 0", overlap, multi); end
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || op_a !== 3'd0) begin
      errors++; $display("FAIL nominal_idle_after: busy=%b done=%b op=%0d expected 0 0 0", busy_a, done_a, op_a);
    end
  endtask

  task automatic test_start_held();
    sel = 0;
    start_a = 1'b1; tick();
    trace(100);
    checks++;
    if (done_first != 79 || done_cnt != 21) begin errors++; $display("FAIL held_done: first=%0d count=%0d expected 79 21", done_first, done_cnt); end
    checks++;
    if (ld_cnt != 1) begin errors++; $display("FAIL held_no_restart: loads=%0d expected 1", ld_cnt); end
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL held_done_level: got %b expected 1", done_a); end
    start_a = 1'b0; tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || ld_a !== 1'b0) begin
      errors++; $display("FAIL held_release_idle: done=%b busy=%b ld=%b expected 0 0 0", done_a, busy_a, ld_a);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++;
    if (ld_a !== 1'b1) begin errors++; $display("FAIL held_restart_load: got %b expected 1", ld_a); end
    trace(85);
    checks++;
    if (done_first != 79) begin errors++; $display("FAIL held_restart_latency: got %0d expected 79", done_first); end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    trace(39);
    Reset = 1'b1; tick();
    checks++;
    if ({done_a, busy_a, ld_a, we_a, op_a, idx_a, col_a, pt_a} !== 15'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", {done_a, busy_a, ld_a, we_a, op_a, idx_a, col_a, pt_a});
    end
    Reset = 1'b0;
    trace(90);
    checks++;
    if (pt_cnt != 0 || done_cnt != 0 || ld_cnt != 0 || strokes != 0) begin
      errors++; $display("FAIL midreset_quiet: pt=%0d done=%0d ld=%0d we=%0d expected 0 0 0 0", pt_cnt, done_cnt, ld_cnt, strokes);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    trace(85);
    checks++;
    if (done_first != 79 || pt_k != 78) begin errors++; $display("FAIL midreset_rerun: done=%0d pt=%0d expected 79 78", done_first, pt_k); end
  endtask

  task automatic test_param_corner();
    sel = 1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    checks++;
    if (ld_b !== 1'b1) begin errors++; $display("FAIL corner_load: got %b expected 1", ld_b); end
    trace(20);
    checks++;
    if (done_first != 14 || done_cnt != 1) begin errors++; $display("FAIL corner_done: first=%0d count=%0d expected 14 1", done_first, done_cnt); end
    checks++;
    if (pt_k != 13 || pt_cnt != 1) begin errors++; $display("FAIL corner_pt_we: at=%0d count=%0d expected 13 1", pt_k, pt_cnt); end
    checks++;
    if (first_ark_k != 2) begin errors++; $display("FAIL corner_ark_init_cycle: got %0d expected 2", first_ark_k); end
    checks++;
    if (ark_n != 3) begin errors++; $display("FAIL corner_ark_count: got %0d expected 3", ark_n); end
    for (int i = 0; i < 3 && i < ark_n; i++) begin
      checks++;
      if (ark_keys[i] !== 4'(2 - i)) begin
        errors++; $display("FAIL corner_ark_key[%0d]: got %0d expected %0d", i, ark_keys[i], 2 - i);
      end
    end
    checks++;
    if (imc_n != 4 || strokes != 11) begin errors++; $display("FAIL corner_strokes: imc=%0d total=%0d expected 4 11", imc_n, strokes); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_held();
    test_reset_mid();
    test_param_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
